// File: rtl/mem_wb_pipe_reg.sv
// ============================================================================
// Module   : mem_wb_pipe_reg
// Purpose  : Elastic MEM/WB pipeline register with a one-entry skid buffer,
//            flush, write-back data mux, forwarding copy and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int MTR_W   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_load_data,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [DATA_W-1:0]  in_link_addr,
    input  logic [REG_W-1:0]   in_dest_reg,
    input  logic               in_reg_write,
    input  logic [MTR_W-1:0]   in_mem_to_reg,

    input  logic               flush,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_wb_data,
    output logic [REG_W-1:0]   out_dest_reg,
    output logic               out_reg_write,

    output logic               fwd_valid,
    output logic [REG_W-1:0]   fwd_reg,
    output logic [DATA_W-1:0]  fwd_data,

    output logic [COUNT_W-1:0] retire_count
);

    localparam logic [MTR_W-1:0] c_MTR_ALU  = MTR_W'(0);
    localparam logic [MTR_W-1:0] c_MTR_LOAD = MTR_W'(1);
    localparam logic [MTR_W-1:0] c_MTR_LINK = MTR_W'(2);

    // Main entry (drives the outputs)
    logic               r_main_valid_q,  w_main_valid_d;
    logic [DATA_W-1:0]  r_main_load_q,   w_main_load_d;
    logic [DATA_W-1:0]  r_main_alu_q,    w_main_alu_d;
    logic [DATA_W-1:0]  r_main_link_q,   w_main_link_d;
    logic [REG_W-1:0]   r_main_dest_q,   w_main_dest_d;
    logic               r_main_rw_q,     w_main_rw_d;
    logic [MTR_W-1:0]   r_main_mtr_q,    w_main_mtr_d;

    // Skid entry
    logic               r_skid_valid_q,  w_skid_valid_d;
    logic [DATA_W-1:0]  r_skid_load_q,   w_skid_load_d;
    logic [DATA_W-1:0]  r_skid_alu_q,    w_skid_alu_d;
    logic [DATA_W-1:0]  r_skid_link_q,   w_skid_link_d;
    logic [REG_W-1:0]   r_skid_dest_q,   w_skid_dest_d;
    logic               r_skid_rw_q,     w_skid_rw_d;
    logic [MTR_W-1:0]   r_skid_mtr_q,    w_skid_mtr_d;

    logic               r_fwd_valid_q,   w_fwd_valid_d;
    logic [REG_W-1:0]   r_fwd_reg_q,     w_fwd_reg_d;
    logic [DATA_W-1:0]  r_fwd_data_q,    w_fwd_data_d;
    logic [COUNT_W-1:0] r_retire_cnt_q,  w_retire_cnt_d;

    logic               w_accept;
    logic               w_retire;
    logic [DATA_W-1:0]  w_wb_data;

    assign w_accept = in_valid & ~r_skid_valid_q;
    assign w_retire = r_main_valid_q & out_ready;

    always_comb begin
        w_wb_data = r_main_alu_q;
        case (r_main_mtr_q)
            c_MTR_ALU:  w_wb_data = r_main_alu_q;
            c_MTR_LOAD: w_wb_data = r_main_load_q;
            c_MTR_LINK: w_wb_data = r_main_link_q;
            default:    w_wb_data = r_main_alu_q;
        endcase
    end

    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_load_d  = r_main_load_q;
        w_main_alu_d   = r_main_alu_q;
        w_main_link_d  = r_main_link_q;
        w_main_dest_d  = r_main_dest_q;
        w_main_rw_d    = r_main_rw_q;
        w_main_mtr_d   = r_main_mtr_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_load_d  = r_skid_load_q;
        w_skid_alu_d   = r_skid_alu_q;
        w_skid_link_d  = r_skid_link_q;
        w_skid_dest_d  = r_skid_dest_q;
        w_skid_rw_d    = r_skid_rw_q;
        w_skid_mtr_d   = r_skid_mtr_q;

        if (r_skid_valid_q) begin
            // in_ready is low here, so nothing new can arrive this cycle
            if (w_retire) begin
                w_main_valid_d = 1'b1;
                w_main_load_d  = r_skid_load_q;
                w_main_alu_d   = r_skid_alu_q;
                w_main_link_d  = r_skid_link_q;
                w_main_dest_d  = r_skid_dest_q;
                w_main_rw_d    = r_skid_rw_q;
                w_main_mtr_d   = r_skid_mtr_q;
                w_skid_valid_d = 1'b0;
            end
        end else if (!r_main_valid_q || w_retire) begin
            w_main_valid_d = w_accept;
            if (w_accept) begin
                w_main_load_d = in_load_data;
                w_main_alu_d  = in_alu_result;
                w_main_link_d = in_link_addr;
                w_main_dest_d = in_dest_reg;
                w_main_rw_d   = in_reg_write;
                w_main_mtr_d  = in_mem_to_reg;
            end
        end else if (w_accept) begin
            w_skid_valid_d = 1'b1;
            w_skid_load_d  = in_load_data;
            w_skid_alu_d   = in_alu_result;
            w_skid_link_d  = in_link_addr;
            w_skid_dest_d  = in_dest_reg;
            w_skid_rw_d    = in_reg_write;
            w_skid_mtr_d   = in_mem_to_reg;
        end

        if (flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end
    end

    // Forwarding and retire bookkeeping see retirements even during flush
    always_comb begin
        w_fwd_valid_d  = w_retire & r_main_rw_q & (r_main_dest_q != '0);
        w_fwd_reg_d    = r_fwd_reg_q;
        w_fwd_data_d   = r_fwd_data_q;
        w_retire_cnt_d = r_retire_cnt_q;
        if (w_fwd_valid_d) begin
            w_fwd_reg_d  = r_main_dest_q;
            w_fwd_data_d = w_wb_data;
        end
        if (w_retire) begin
            w_retire_cnt_d = r_retire_cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid_q <= 1'b0;
            r_main_load_q  <= '0;
            r_main_alu_q   <= '0;
            r_main_link_q  <= '0;
            r_main_dest_q  <= '0;
            r_main_rw_q    <= 1'b0;
            r_main_mtr_q   <= '0;
            r_skid_valid_q <= 1'b0;
            r_skid_load_q  <= '0;
            r_skid_alu_q   <= '0;
            r_skid_link_q  <= '0;
            r_skid_dest_q  <= '0;
            r_skid_rw_q    <= 1'b0;
            r_skid_mtr_q   <= '0;
            r_fwd_valid_q  <= 1'b0;
            r_fwd_reg_q    <= '0;
            r_fwd_data_q   <= '0;
            r_retire_cnt_q <= '0;
        end else begin
            r_main_valid_q <= w_main_valid_d;
            r_main_load_q  <= w_main_load_d;
            r_main_alu_q   <= w_main_alu_d;
            r_main_link_q  <= w_main_link_d;
            r_main_dest_q  <= w_main_dest_d;
            r_main_rw_q    <= w_main_rw_d;
            r_main_mtr_q   <= w_main_mtr_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_load_q  <= w_skid_load_d;
            r_skid_alu_q   <= w_skid_alu_d;
            r_skid_link_q  <= w_skid_link_d;
            r_skid_dest_q  <= w_skid_dest_d;
            r_skid_rw_q    <= w_skid_rw_d;
            r_skid_mtr_q   <= w_skid_mtr_d;
            r_fwd_valid_q  <= w_fwd_valid_d;
            r_fwd_reg_q    <= w_fwd_reg_d;
            r_fwd_data_q   <= w_fwd_data_d;
            r_retire_cnt_q <= w_retire_cnt_d;
        end
    end

    assign in_ready      = ~r_skid_valid_q;
    assign out_valid     = r_main_valid_q;
    assign out_wb_data   = w_wb_data;
    assign out_dest_reg  = r_main_dest_q;
    assign out_reg_write = r_main_valid_q & r_main_rw_q;
    assign fwd_valid     = r_fwd_valid_q;
    assign fwd_reg       = r_fwd_reg_q;
    assign fwd_data      = r_fwd_data_q;
    assign retire_count  = r_retire_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
// ============================================================================
// Module   : tb_mem_wb_pipe_reg
// Purpose  : Vector-table and directed-sequence bench for mem_wb_pipe_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int MTR_W   = 2;
    localparam int COUNT_W = 4;
    localparam int NVEC    = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  in_load_data = '0;
    logic [DATA_W-1:0]  in_alu_result = '0;
    logic [DATA_W-1:0]  in_link_addr = '0;
    logic [REG_W-1:0]   in_dest_reg = '0;
    logic               in_reg_write = 1'b0;
    logic [MTR_W-1:0]   in_mem_to_reg = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  out_wb_data;
    logic [REG_W-1:0]   out_dest_reg;
    logic               out_reg_write;
    logic               fwd_valid;
    logic [REG_W-1:0]   fwd_reg;
    logic [DATA_W-1:0]  fwd_data;
    logic [COUNT_W-1:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_pipe_reg #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .MTR_W   (MTR_W),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_load_data  (in_load_data),
        .in_alu_result (in_alu_result),
        .in_link_addr  (in_link_addr),
        .in_dest_reg   (in_dest_reg),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_wb_data   (out_wb_data),
        .out_dest_reg  (out_dest_reg),
        .out_reg_write (out_reg_write),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               iv;
        logic               ordy;
        logic               fl;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  ld;
        logic [DATA_W-1:0]  lk;
        logic [REG_W-1:0]   dst;
        logic               rw;
        logic [MTR_W-1:0]   mtr;
        logic               e_ov;
        logic               e_ir;
        logic [DATA_W-1:0]  e_wb;
        logic [REG_W-1:0]   e_dst;
        logic               e_rw;
        logic               e_fv;
        logic [REG_W-1:0]   e_fr;
        logic [DATA_W-1:0]  e_fd;
        logic [COUNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"},     64'(out_valid),     64'd0);
        check({tag, " in_ready"},      64'(in_ready),      64'd1);
        check({tag, " out_reg_write"}, 64'(out_reg_write), 64'd0);
        check({tag, " out_wb_data"},   64'(out_wb_data),   64'd0);
        check({tag, " out_dest_reg"},  64'(out_dest_reg),  64'd0);
        check({tag, " fwd_valid"},     64'(fwd_valid),     64'd0);
        check({tag, " fwd_reg"},       64'(fwd_reg),       64'd0);
        check({tag, " fwd_data"},      64'(fwd_data),      64'd0);
        check({tag, " retire_count"},  64'(retire_count),  64'd0);
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] ld,
                         input logic [DATA_W-1:0] lk, input logic [REG_W-1:0] dst,
                         input logic rw, input logic [MTR_W-1:0] mtr);
        in_valid      = iv;
        out_ready     = ordy;
        flush         = fl;
        in_alu_result = alu;
        in_load_data  = ld;
        in_link_addr  = lk;
        in_dest_reg   = dst;
        in_reg_write  = rw;
        in_mem_to_reg = mtr;
    endtask

    initial begin
        // iv ordy fl | alu ld lk dst rw mtr | ov ir wb dst rw | fv fr fd | cnt
        vecs[0]  = '{1,1,0, 'h10,0,0, 3,1,0, 1,1,'h10,3,1, 0,0,0, 0};
        vecs[1]  = '{1,1,0, 'h20,0,0, 3,1,0, 1,1,'h20,3,1, 1,3,'h10, 1};
        vecs[2]  = '{1,1,0, 'h30,0,0, 3,1,0, 1,1,'h30,3,1, 1,3,'h20, 2};
        vecs[3]  = '{1,1,0, 'h40,0,0, 3,1,0, 1,1,'h40,3,1, 1,3,'h30, 3};
        vecs[4]  = '{0,1,0, 0,0,0, 0,0,0, 0,1,0,0,0, 1,3,'h40, 4};
        vecs[5]  = '{1,0,0, 'h11,0,0, 5,1,0, 1,1,'h11,5,1, 0,3,'h40, 4};
        vecs[6]  = '{1,0,0, 'h22,0,0, 5,1,0, 1,0,'h11,5,1, 0,3,'h40, 4};
        vecs[7]  = '{1,1,0, 'h33,0,0, 6,1,0, 1,1,'h22,5,1, 1,5,'h11, 5};
        vecs[8]  = '{0,1,0, 0,0,0, 0,0,0, 0,1,0,0,0, 1,5,'h22, 6};
        vecs[9]  = '{1,0,0, 'h99,'hDEADBEEF,0, 7,1,1, 1,1,'hDEADBEEF,7,1, 0,5,'h22, 6};
        vecs[10] = '{0,1,0, 0,0,0, 0,0,0, 0,1,0,0,0, 1,7,'hDEADBEEF, 7};
        vecs[11] = '{1,0,0, 0,'hCAFEF00D,0, 0,1,1, 1,1,'hCAFEF00D,0,1, 0,7,'hDEADBEEF, 7};
        vecs[12] = '{0,1,0, 0,0,0, 0,0,0, 0,1,0,0,0, 0,7,'hDEADBEEF, 8};
        vecs[13] = '{1,0,0, 'h55,0,'h00400008, 9,0,2, 1,1,'h00400008,9,0, 0,7,'hDEADBEEF, 8};
        vecs[14] = '{1,1,0, 'h1234,1,2, 10,1,3, 1,1,'h1234,10,1, 0,7,'hDEADBEEF, 9};
        vecs[15] = '{1,0,0, 'h77,0,0, 11,1,0, 1,0,'h1234,10,1, 0,7,'hDEADBEEF, 9};
        vecs[16] = '{1,0,1, 'h78,0,0, 11,1,0, 0,1,0,0,0, 0,7,'hDEADBEEF, 9};
        vecs[17] = '{1,0,1, 'h88,0,0, 11,1,0, 0,1,0,0,0, 0,7,'hDEADBEEF, 9};
        vecs[18] = '{1,0,0, 'h66,0,0, 12,1,0, 1,1,'h66,12,1, 0,7,'hDEADBEEF, 9};
        vecs[19] = '{0,1,1, 0,0,0, 0,0,0, 0,1,0,0,0, 1,12,'h66, 10};

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].alu, vecs[i].ld,
                  vecs[i].lk, vecs[i].dst, vecs[i].rw, vecs[i].mtr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i),     64'(out_valid),     64'(vecs[i].e_ov));
            check($sformatf("v%0d in_ready", i),      64'(in_ready),      64'(vecs[i].e_ir));
            check($sformatf("v%0d out_reg_write", i), 64'(out_reg_write), 64'(vecs[i].e_rw));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d out_wb_data", i),  64'(out_wb_data),  64'(vecs[i].e_wb));
                check($sformatf("v%0d out_dest_reg", i), 64'(out_dest_reg), 64'(vecs[i].e_dst));
            end
            check($sformatf("v%0d fwd_valid", i),    64'(fwd_valid),    64'(vecs[i].e_fv));
            check($sformatf("v%0d fwd_reg", i),      64'(fwd_reg),      64'(vecs[i].e_fr));
            check($sformatf("v%0d fwd_data", i),     64'(fwd_data),     64'(vecs[i].e_fd));
            check($sformatf("v%0d retire_count", i), 64'(retire_count), 64'(vecs[i].e_cnt));
        end

        // Asynchronous reset between edges with main and skid both full
        @(negedge clk);
        drive(1, 0, 0, 'hAB, 0, 0, 13, 1, 0);
        @(negedge clk);
        drive(1, 0, 0, 'hCD, 0, 0, 14, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pre-async in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async");

        // Reset dominates a concurrent flush across an edge
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst+flush");
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst out_valid", 64'(out_valid), 64'd0);
        check("post-rst in_ready",  64'(in_ready),  64'd1);

        // Counter wrap: 16 retirements return to 0, a 17th gives 1
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive(1, 1, 0, DATA_W'(k), 0, 0, 2, 1, 0);
        end
        @(posedge clk);
        #1;
        check("wrap count 16", 64'(retire_count), 64'd0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("wrap count 17", 64'(retire_count), 64'd1);
        check("wrap last fwd_data", 64'(fwd_data), 64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
